// File: rtl/fix_field_tokenizer_pkg.sv
// Shared constants and state type for the FIX byte-stream tokenizer.
package fix_field_tokenizer_pkg;

    localparam logic [7:0] C_SOH  = 8'h01;
    localparam logic [7:0] C_EQ   = 8'h3D;
    localparam logic [7:0] C_ZERO = 8'h30;
    localparam logic [7:0] C_NINE = 8'h39;

    localparam logic [31:0] c_t_beginString = 32'd8;
    localparam logic [31:0] c_t_checksum    = 32'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAG,
        ST_VALUE,
        ST_DISCARD
    } tokenizer_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= C_ZERO) && (b <= C_NINE);
    endfunction

endpackage

// File: rtl/fix_checksum_unit.sv
// FIX tag-10 checksum: running byte sum of the message body and the received
// three-digit trailer, compared when the trailer field closes.
module fix_checksum_unit
    import fix_field_tokenizer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_stb_i,      // byte belongs to the current field
    input  logic [7:0] byte_i,
    input  logic       msg_start_i,     // first byte of a new message
    input  logic       field_end_i,     // byte is the field's SOH
    input  logic       trailer_field_i, // current field is tag 10
    input  logic       trailer_byte_i,  // value byte of the tag-10 field
    input  logic       trailer_done_i,  // tag-10 field closed with a value
    input  logic       valid_clr_i,
    output logic       ck_done_o,
    output logic       ck_valid_o
);

    logic [7:0] field_sum_q, field_sum_d;
    logic [7:0] msg_sum_q,   msg_sum_d;
    logic [9:0] rx_ck_q,     rx_ck_d;
    logic [2:0] ck_cnt_q,    ck_cnt_d;
    logic       ck_bad_q,    ck_bad_d;
    logic       done_q,      done_d;
    logic       valid_q,     valid_d;

    always_comb begin
        field_sum_d = field_sum_q;
        msg_sum_d   = msg_sum_q;
        rx_ck_d     = rx_ck_q;
        ck_cnt_d    = ck_cnt_q;
        ck_bad_d    = ck_bad_q;
        done_d      = 1'b0;
        valid_d     = valid_q;

        if (byte_stb_i) begin
            if (msg_start_i) begin
                msg_sum_d   = 8'd0;
                field_sum_d = byte_i;
                rx_ck_d     = 10'd0;
                ck_cnt_d    = 3'd0;
                ck_bad_d    = 1'b0;
            end else if (field_end_i) begin
                // The trailer's own bytes are never part of the body sum.
                if (!trailer_field_i)
                    msg_sum_d = msg_sum_q + field_sum_q + byte_i;
                field_sum_d = 8'd0;
            end else begin
                field_sum_d = field_sum_q + byte_i;
            end

            if (trailer_byte_i) begin
                rx_ck_d  = rx_ck_q * 10'd10 + {2'b00, byte_i - C_ZERO};
                ck_cnt_d = (ck_cnt_q == 3'd4) ? ck_cnt_q : ck_cnt_q + 3'd1;
                ck_bad_d = ck_bad_q | ~is_digit(byte_i);
            end
        end

        if (valid_clr_i)
            valid_d = 1'b0;

        if (trailer_done_i) begin
            done_d   = 1'b1;
            valid_d  = (ck_cnt_q == 3'd3) && !ck_bad_q && (rx_ck_q == {2'b00, msg_sum_q});
            rx_ck_d  = 10'd0;
            ck_cnt_d = 3'd0;
            ck_bad_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_sum_q <= 8'd0;
            msg_sum_q   <= 8'd0;
            rx_ck_q     <= 10'd0;
            ck_cnt_q    <= 3'd0;
            ck_bad_q    <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            field_sum_q <= field_sum_d;
            msg_sum_q   <= msg_sum_d;
            rx_ck_q     <= rx_ck_d;
            ck_cnt_q    <= ck_cnt_d;
            ck_bad_q    <= ck_bad_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
        end
    end

    assign ck_done_o  = done_q;
    assign ck_valid_o = valid_q;

endmodule

// File: rtl/fix_field_tokenizer.sv
// Splits a raw FIX byte stream into tag/value pulses, frames messages and
// reports the tag-10 checksum result.
module fix_field_tokenizer
    import fix_field_tokenizer_pkg::*;
#(
    parameter int         VALUE_WIDTH    = 64,
    parameter int         MAX_TAG_DIGITS = 9,
    parameter logic [7:0] SOH_CHAR       = C_SOH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   tag_valid_o,
    output logic [31:0]            tag_o,
    output logic                   val_valid_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic                   val_trunc_o,
    output logic                   start_of_message_o,
    output logic                   end_of_message_o,
    output logic                   checksum_done_o,
    output logic                   checksum_validity_o,
    output logic                   frame_error_o
);

    localparam int VAL_BYTES = VALUE_WIDTH / 8;
    localparam int CNT_W     = $clog2(VAL_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(VAL_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VAL_BYTES);
    localparam logic [3:0]       TAG_MAX  = 4'(MAX_TAG_DIGITS);

    tokenizer_state_t state_q, state_d;
    logic [31:0]            tag_acc_q, tag_acc_d;
    logic [3:0]             tag_cnt_q, tag_cnt_d;
    logic [VALUE_WIDTH-1:0] val_acc_q, val_acc_d;
    logic [CNT_W-1:0]       val_cnt_q, val_cnt_d;
    logic first_q, first_d;
    logic in_msg_q, in_msg_d;
    logic is_ck_q, is_ck_d;

    logic                   tag_vld_q, tag_vld_d;
    logic [31:0]            tag_q, tag_d;
    logic                   sof_q, sof_d;
    logic                   eom_q, eom_d;
    logic                   val_vld_q, val_vld_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic                   trunc_q, trunc_d;
    logic                   ferr_q, ferr_d;

    logic cs_byte, cs_start, cs_end, cs_tbyte, cs_tdone, cs_clr;
    logic is_soh, dig;
    logic [31:0] dval;

    assign is_soh = (byte_i == SOH_CHAR);
    assign dig    = is_digit(byte_i);
    assign dval   = {24'd0, byte_i - C_ZERO};

    always_comb begin
        state_d   = state_q;
        tag_acc_d = tag_acc_q;
        tag_cnt_d = tag_cnt_q;
        val_acc_d = val_acc_q;
        val_cnt_d = val_cnt_q;
        first_d   = first_q;
        in_msg_d  = in_msg_q;
        is_ck_d   = is_ck_q;
        tag_vld_d = 1'b0;
        tag_d     = tag_q;
        sof_d     = 1'b0;
        eom_d     = 1'b0;
        val_vld_d = 1'b0;
        val_d     = val_q;
        trunc_d   = 1'b0;
        ferr_d    = 1'b0;
        cs_byte   = 1'b0;
        cs_start  = 1'b0;
        cs_end    = 1'b0;
        cs_tbyte  = 1'b0;
        cs_tdone  = 1'b0;
        cs_clr    = 1'b0;

        if (byte_valid_i) begin
            cs_byte = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (dig) begin
                        tag_acc_d = dval;
                        tag_cnt_d = 4'd1;
                        first_d   = 1'b1;
                        in_msg_d  = 1'b1;
                        is_ck_d   = 1'b0;
                        cs_start  = 1'b1;
                        state_d   = ST_TAG;
                    end else if (is_soh) begin
                        cs_byte = 1'b0;
                    end else begin
                        ferr_d   = 1'b1;
                        in_msg_d = 1'b0;
                        state_d  = ST_DISCARD;
                    end
                end
                ST_TAG: begin
                    if (dig && tag_cnt_q != TAG_MAX) begin
                        tag_acc_d = tag_acc_q * 32'd10 + dval;
                        tag_cnt_d = tag_cnt_q + 4'd1;
                    end else if (byte_i == C_EQ && tag_cnt_q != 4'd0) begin
                        tag_vld_d = 1'b1;
                        tag_d     = tag_acc_q;
                        sof_d     = first_q;
                        cs_clr    = first_q;
                        eom_d     = (tag_acc_q == c_t_checksum) && !first_q;
                        is_ck_d   = (tag_acc_q == c_t_checksum);
                        first_d   = 1'b0;
                        val_acc_d = '0;
                        val_cnt_d = '0;
                        state_d   = ST_VALUE;
                    end else begin
                        ferr_d  = 1'b1;
                        cs_end  = is_soh;
                        state_d = ST_DISCARD;
                    end
                end
                ST_VALUE: begin
                    if (!is_soh) begin
                        val_acc_d = {val_acc_q[VALUE_WIDTH-9:0], byte_i};
                        val_cnt_d = (val_cnt_q == CNT_SAT) ? val_cnt_q : val_cnt_q + 1'b1;
                        cs_tbyte  = is_ck_q;
                    end else begin
                        cs_end = 1'b1;
                        if (val_cnt_q != '0) begin
                            val_vld_d = 1'b1;
                            val_d     = val_acc_q;
                            trunc_d   = (val_cnt_q > CNT_FULL);
                            tag_acc_d = 32'd0;
                            tag_cnt_d = 4'd0;
                            is_ck_d   = 1'b0;
                            if (is_ck_q) begin
                                cs_tdone = 1'b1;
                                in_msg_d = 1'b0;
                                state_d  = ST_IDLE;
                            end else begin
                                state_d  = ST_TAG;
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (is_soh) begin
                        cs_end    = 1'b1;
                        is_ck_d   = 1'b0;
                        tag_acc_d = 32'd0;
                        tag_cnt_d = 4'd0;
                        // A bad first field never opened a message.
                        if (in_msg_q && !first_q) begin
                            state_d = ST_TAG;
                        end else begin
                            in_msg_d = 1'b0;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tag_acc_q <= 32'd0;
            tag_cnt_q <= 4'd0;
            val_acc_q <= '0;
            val_cnt_q <= '0;
            first_q   <= 1'b0;
            in_msg_q  <= 1'b0;
            is_ck_q   <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_q     <= 32'd0;
            sof_q     <= 1'b0;
            eom_q     <= 1'b0;
            val_vld_q <= 1'b0;
            val_q     <= '0;
            trunc_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_acc_q <= tag_acc_d;
            tag_cnt_q <= tag_cnt_d;
            val_acc_q <= val_acc_d;
            val_cnt_q <= val_cnt_d;
            first_q   <= first_d;
            in_msg_q  <= in_msg_d;
            is_ck_q   <= is_ck_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            sof_q     <= sof_d;
            eom_q     <= eom_d;
            val_vld_q <= val_vld_d;
            val_q     <= val_d;
            trunc_q   <= trunc_d;
            ferr_q    <= ferr_d;
        end
    end

    fix_checksum_unit u_ck (
        .clk             (clk),
        .rst             (rst),
        .byte_stb_i      (cs_byte),
        .byte_i          (byte_i),
        .msg_start_i     (cs_start),
        .field_end_i     (cs_end),
        .trailer_field_i (is_ck_q),
        .trailer_byte_i  (cs_tbyte),
        .trailer_done_i  (cs_tdone),
        .valid_clr_i     (cs_clr),
        .ck_done_o       (checksum_done_o),
        .ck_valid_o      (checksum_validity_o)
    );

    assign tag_valid_o        = tag_vld_q;
    assign tag_o              = tag_q;
    assign start_of_message_o = sof_q;
    assign end_of_message_o   = eom_q;
    assign val_valid_o        = val_vld_q;
    assign val_o              = val_q;
    assign val_trunc_o        = trunc_q;
    assign frame_error_o      = ferr_q;

endmodule

// File: tb/tb_fix_field_tokenizer.sv
// Directed scoreboard bench for fix_field_tokenizer with '|' as the delimiter.
module tb_fix_field_tokenizer;

    localparam logic [7:0] SOH = 8'h7C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        tag_valid_o, val_valid_o, val_trunc_o;
    logic [31:0] tag_o;
    logic [63:0] val_o;
    logic        start_of_message_o, end_of_message_o;
    logic        checksum_done_o, checksum_validity_o, frame_error_o;

    fix_field_tokenizer #(.VALUE_WIDTH(64), .MAX_TAG_DIGITS(9), .SOH_CHAR(SOH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .byte_valid_i        (byte_valid_i),
        .byte_i              (byte_i),
        .tag_valid_o         (tag_valid_o),
        .tag_o               (tag_o),
        .val_valid_o         (val_valid_o),
        .val_o               (val_o),
        .val_trunc_o         (val_trunc_o),
        .start_of_message_o  (start_of_message_o),
        .end_of_message_o    (end_of_message_o),
        .checksum_done_o     (checksum_done_o),
        .checksum_validity_o (checksum_validity_o),
        .frame_error_o       (frame_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 tag, 1 value, 2 frame error
        logic [31:0] tag;
        logic        sof;
        logic        eom;
        logic [63:0] val;
        logic        trunc;
        logic        ckd;
        logic        ckv;
    } ev_t;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] str2val(input string s);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < s.len(); i++) v = {v[55:0], s[i]};
        return v;
    endfunction

    function automatic int body_sum(input string s);
        int acc = 0;
        for (int i = 0; i < s.len(); i++) acc = (acc + int'(s[i])) % 256;
        return acc;
    endfunction

    task automatic push_tag(input int t, input logic sof, input logic eom);
        ev_t e;
        e = '{kind: 0, tag: t, sof: sof, eom: eom, val: 64'd0, trunc: 1'b0, ckd: 1'b0, ckv: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_val(input string v, input logic ckd, input logic ckv);
        ev_t e;
        e = '{kind: 1, tag: 32'd0, sof: 1'b0, eom: 1'b0, val: str2val(v),
              trunc: (v.len() > 8), ckd: ckd, ckv: ckv};
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e = '{kind: 2, tag: 32'd0, sof: 1'b0, eom: 1'b0, val: 64'd0, trunc: 1'b0, ckd: 1'b0, ckv: 1'b0};
        exp_q.push_back(e);
    endtask

    // gap > 0 inserts idle cycles (with a junk byte) after every valid byte
    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i       = s[i];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                byte_valid_i = 1'b0;
                byte_i       = 8'h3D;
            end
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tag_valid"}, tag_valid_o, 1'b0);
        check({name, "_val_valid"}, val_valid_o, 1'b0);
        check({name, "_tag"}, tag_o, 32'd0);
        check({name, "_val"}, val_o, 64'd0);
        check({name, "_flags"}, {val_trunc_o, start_of_message_o, end_of_message_o,
                                 checksum_done_o, checksum_validity_o, frame_error_o}, 6'd0);
    endtask

    // Input byte seen by the DUT at the last edge, for latency checks.
    logic       prev_v = 1'b0;
    logic [7:0] prev_b = 8'h00;
    always @(posedge clk) begin
        prev_v <= byte_valid_i;
        prev_b <= byte_i;
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (tag_valid_o || val_valid_o || frame_error_o)) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL spurious_pulse: observed tag/val/err %b%b%b expected none",
                       tag_valid_o, val_valid_o, frame_error_o);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {tag_valid_o, val_valid_o, frame_error_o},
                      (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
                if (e.kind == 0) begin
                    check("tag_o", tag_o, e.tag);
                    check("sof_eom", {start_of_message_o, end_of_message_o}, {e.sof, e.eom});
                    check("tag_latency", {prev_v, prev_b}, {1'b1, 8'h3D});
                    if (e.sof) check("ckv_clear_at_sof", checksum_validity_o, 1'b0);
                end else if (e.kind == 1) begin
                    check("val_o", val_o, e.val);
                    check("val_trunc", val_trunc_o, e.trunc);
                    check("val_latency", {prev_v, prev_b}, {1'b1, SOH});
                    check("ck_done", checksum_done_o, e.ckd);
                    if (e.ckd) check("ck_validity", checksum_validity_o, e.ckv);
                end
            end
        end else if (!rst && checksum_done_o) begin
            compared++;
            mismatched++;
            $error("FAIL stray_ck_done: observed 1 expected 0");
        end
    end

    initial begin
        string body, ck;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Message 1: good checksum, middle field sent with idle gaps.
        body = "8=FIX.4.3|35=A|";
        push_tag(8, 1'b1, 1'b0);
        push_val("FIX.4.3", 1'b0, 1'b0);
        send("8=FIX.4.3|", 0);
        push_tag(35, 1'b0, 1'b0);
        push_val("A", 1'b0, 1'b0);
        send("35=A|", 1);
        ck = $sformatf("%03d", body_sum(body));
        push_tag(10, 1'b0, 1'b1);
        push_val(ck, 1'b1, 1'b1);
        send({"10=", ck, "|"}, 0);
        check("ckv_after_msg1", checksum_validity_o, 1'b1);

        // Message 2: checksum off by one.
        body = "8=A|";
        ck = $sformatf("%03d", (body_sum(body) + 1) % 256);
        push_tag(8, 1'b1, 1'b0);
        push_val("A", 1'b0, 1'b0);
        push_tag(10, 1'b0, 1'b1);
        push_val(ck, 1'b1, 1'b0);
        send({body, "10=", ck, "|"}, 0);

        // Over-long tag in first field, then truncated value, empty value,
        // a field swallowed by discard, and a trailer covering all of it.
        push_err();
        send("1234567890=X|", 0);
        body = "8=ABCDEFGHIJ|49=|1=Z|";
        push_tag(8, 1'b1, 1'b0);
        push_val("ABCDEFGHIJ", 1'b0, 1'b0);
        push_tag(49, 1'b0, 1'b0);
        push_err();
        send(body, 0);
        ck = $sformatf("%03d", body_sum(body));
        push_tag(10, 1'b0, 1'b1);
        push_val(ck, 1'b1, 1'b1);
        send({"10=", ck, "|"}, 0);

        // Garbage in IDLE, a stray SOH, then reset with validity still set.
        push_err();
        send("X|", 0);
        send("|", 0);
        check("ckv_held", checksum_validity_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_idle");
        rst = 1'b0;

        // Reset in the middle of a value abandons the message.
        push_tag(8, 1'b1, 1'b0);
        send("8=AB", 0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;

        body = "8=A|";
        ck = $sformatf("%03d", body_sum(body));
        push_tag(8, 1'b1, 1'b0);
        push_val("A", 1'b0, 1'b0);
        push_tag(10, 1'b0, 1'b1);
        push_val(ck, 1'b1, 1'b1);
        send({body, "10=", ck, "|"}, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
